// File: rtl/mult_datapath_if.sv
// Bundles the strobe and operand inputs and the register/status outputs of the multiplier datapath.
// Latency: none. The interface is pure wiring.
// Backpressure: none. The strobes are single-cycle commands with no handshake.
//
// Ports (by modport):
//   master (control unit / bench): drives Clr_Ld, ClearA, Add, Sub, Shift, S;
//                                  observes Aval, Bval, X, M, Product, Done
//   slave  (datapath)            : the mirror image of master
interface mult_datapath_if #(
  parameter int WIDTH = 8
);
  logic               Clr_Ld;
  logic               ClearA;
  logic               Add;
  logic               Sub;
  logic               Shift;
  logic [WIDTH-1:0]   S;
  logic [WIDTH-1:0]   Aval;
  logic [WIDTH-1:0]   Bval;
  logic               X;
  logic               M;
  logic [2*WIDTH-1:0] Product;
  logic               Done;

  modport master (
    output Clr_Ld, ClearA, Add, Sub, Shift, S,
    input  Aval, Bval, X, M, Product, Done
  );

  modport slave (
    input  Clr_Ld, ClearA, Add, Sub, Shift, S,
    output Aval, Bval, X, M, Product, Done
  );
endinterface

// File: rtl/mult_datapath.sv
// X:A:B product register, a sign-extended add/sub unit against S, and a saturating shift counter for the add-shift multiplier.
// Latency: one cycle. A strobe sampled at an edge is visible on the outputs right after that edge.
// Backpressure: none. Exactly one action executes per edge, picked by fixed priority.
//
// Ports:
//   Clk   : rising-edge clock
//   Reset : asynchronous, active-low; clears A, B, X and the count
//   dp    : slave side of mult_datapath_if. It carries the strobes
//           (Clr_Ld/ClearA/Add/Sub/Shift) and the S operand in, and
//           carries Aval/Bval/X/M/Product/Done out.
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  mult_datapath_if.slave dp
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             x_q, x_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // The adder is one bit wider than the operands. r[WIDTH] becomes the new X,
  // and any carry above it is dropped.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {a_q[WIDTH-1], a_q} + {dp.S[WIDTH-1], dp.S};
    diff = {a_q[WIDTH-1], a_q} - {dp.S[WIDTH-1], dp.S};
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    x_d   = x_q;
    cnt_d = cnt_q;
    if (dp.Clr_Ld) begin
      b_d   = dp.S;
      a_d   = '0;
      x_d   = 1'b0;
      cnt_d = '0;
    end else if (dp.Sub) begin
      a_d = diff[WIDTH-1:0];
      x_d = diff[WIDTH];
    end else if (dp.Add) begin
      a_d = sum[WIDTH-1:0];
      x_d = sum[WIDTH];
    end else if (dp.Shift) begin
      a_d = {x_q, a_q[WIDTH-1:1]};
      b_d = {a_q[0], b_q[WIDTH-1:1]};
      // Extra shifts still move data. The counter stops at WIDTH so that Done stays high.
      if (cnt_q != CW'(WIDTH)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (dp.ClearA) begin
      // The control unit holds ClearA high through the early bit states, so
      // ClearA only takes effect when no arithmetic strobe is active.
      a_d   = '0;
      x_d   = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      a_q   <= '0;
      b_q   <= '0;
      x_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      x_q   <= x_d;
      cnt_q <= cnt_d;
    end
  end

  assign dp.Aval    = a_q;
  assign dp.Bval    = b_q;
  assign dp.X       = x_q;
  assign dp.M       = b_q[0];
  assign dp.Product = {a_q, b_q};
  assign dp.Done    = (cnt_q == CW'(WIDTH));

endmodule

// File: tb/tb_mult_datapath.sv
// Directed self-checking bench for mult_datapath. Each expected value is a hand-computed constant.
// Latency: checks are taken 1 time unit after the rising edge that executes each strobe.
// Backpressure: none. Strobes are driven for exactly one cycle each.
module tb_mult_datapath;

  logic Clk;
  logic Reset;
  int   n_chk;
  int   n_fail;

  mult_datapath_if #(.WIDTH(8)) dp_if ();

  mult_datapath #(.WIDTH(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .dp    (dp_if.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Applies one strobe set across exactly one rising edge. It returns 1 time
  // unit after that edge with all strobes low again.
  task automatic step(input logic clr, input logic ca, input logic add,
                      input logic sub, input logic sh, input logic [7:0] s);
    dp_if.Clr_Ld = clr;
    dp_if.ClearA = ca;
    dp_if.Add    = add;
    dp_if.Sub    = sub;
    dp_if.Shift  = sh;
    dp_if.S      = s;
    @(posedge Clk);
    #1;
    dp_if.Clr_Ld = 1'b0;
    dp_if.ClearA = 1'b0;
    dp_if.Add    = 1'b0;
    dp_if.Sub    = 1'b0;
    dp_if.Shift  = 1'b0;
  endtask

  // Behaves like the control unit: it adds (or subtracts on the sign bit)
  // when M is set, then shifts. S is held constant throughout.
  task automatic multiply(input logic [7:0] s);
    for (int i = 0; i < 8; i++) begin
      if (dp_if.M) step(1'b0, 1'b0, (i != 7), (i == 7), 1'b0, s);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, s);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    Reset  = 1'b0;
    dp_if.Clr_Ld = 1'b0;
    dp_if.ClearA = 1'b0;
    dp_if.Add    = 1'b0;
    dp_if.Sub    = 1'b0;
    dp_if.Shift  = 1'b0;
    dp_if.S      = 8'h00;
    #2;
    chk("rst_product", 32'(dp_if.Product), 32'h0000);
    chk("rst_x",       32'(dp_if.X),       32'h0);
    chk("rst_done",    32'(dp_if.Done),    32'h0);
    @(negedge Clk);
    Reset = 1'b1;

    // Async reset mid-run, starting from A=0x5A and B=0x33.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
    chk("pre_rst_product", 32'(dp_if.Product), 32'h5A33);
    #1 Reset = 1'b0;
    #1;
    chk("midrst_aval", 32'(dp_if.Aval), 32'h00);
    chk("midrst_bval", 32'(dp_if.Bval), 32'h00);
    chk("midrst_x",    32'(dp_if.X),    32'h0);
    chk("midrst_done", 32'(dp_if.Done), 32'h0);
    @(negedge Clk);
    Reset = 1'b1;

    // Arithmetic boundaries.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7F);
    chk("add_7f_aval", 32'(dp_if.Aval), 32'h7F);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
    chk("add_ovf_aval", 32'(dp_if.Aval), 32'h80);
    chk("add_ovf_x",    32'(dp_if.X),    32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
    chk("sub_ovf_aval", 32'(dp_if.Aval), 32'h7F);
    chk("sub_ovf_x",    32'(dp_if.X),    32'h1);

    // Clr_Ld loads B, and clears A and X.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07);
    chk("ld_bval", 32'(dp_if.Bval), 32'h07);
    chk("ld_aval", 32'(dp_if.Aval), 32'h00);
    chk("ld_x",    32'(dp_if.X),    32'h0);
    chk("ld_m",    32'(dp_if.M),    32'h1);
    chk("ld_done", 32'(dp_if.Done), 32'h0);

    // 7 x -3 = -21.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFD);
    chk("clra_bval", 32'(dp_if.Bval), 32'h07);
    multiply(8'hFD);
    chk("mul1_product", 32'(dp_if.Product), 32'hFFEB);
    chk("mul1_x",       32'(dp_if.X),       32'h1);
    chk("mul1_done",    32'(dp_if.Done),    32'h1);

    // -2 x -2 = 4. The Sub on bit 7 is what cancels the negative partial sum.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE);
    chk("ld2_done", 32'(dp_if.Done), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE);
    multiply(8'hFE);
    chk("mul2_product", 32'(dp_if.Product), 32'h0004);
    chk("mul2_x",       32'(dp_if.X),       32'h0);
    chk("mul2_done",    32'(dp_if.Done),    32'h1);

    // Priority: Add beats Shift, and the count must not advance.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h05);
    chk("prio_add_aval", 32'(dp_if.Aval), 32'h15);
    chk("prio_add_x",    32'(dp_if.X),    32'h0);
    // Shift beats ClearA: 0x15 >> 1 with X=0 gives 0x0A, and this is shift #1.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05);
    chk("prio_sh_aval", 32'(dp_if.Aval), 32'h0A);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
    chk("seven_shift_done", 32'(dp_if.Done), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
    chk("eight_shift_done", 32'(dp_if.Done), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
    chk("nine_shift_done", 32'(dp_if.Done), 32'h1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
    chk("sat_done", 32'(dp_if.Done), 32'h1);

    // ClearA alone clears the count, and B is kept.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
    chk("clra_done", 32'(dp_if.Done), 32'h0);
    chk("clra_aval", 32'(dp_if.Aval), 32'h00);

    // Async reset while Done is high.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
    chk("pre_rst2_done", 32'(dp_if.Done), 32'h1);
    #1 Reset = 1'b0;
    #1;
    chk("rst2_done",    32'(dp_if.Done),    32'h0);
    chk("rst2_product", 32'(dp_if.Product), 32'h0000);
    @(negedge Clk);
    Reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
